iquan_unpack: RTL and testbench
===============================

# iquan_unpack

Decoder-side unpacker and inverse quantizer for the compressed audio stream. It accepts 16-bit packed words, each carrying four 4-bit quantization codes from the encoder-side packer. It emits one reconstructed signed 16-bit sample per accepted output beat, with a valid/ready handshake on both sides and a frame-boundary marker. It sits between the compressed-word transport and the audio reconstruction path.

## Interface
Parameters:
- FRAME_LEN, 256: samples per frame; range 1..65535; sets out_last period.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_word  in  16  packed codes; code k in bits [4k+3:4k], k=0..3.
- in_valid  in  1  in_word valid.
- in_ready  out  1  block can accept in_word this cycle.
- out_sample  out  16  reconstructed signed sample.
- out_valid  out  1  out_sample valid.
- out_ready  in  1  downstream accepts out_sample.
- out_last  out  1  out_sample is the last sample of a frame.

## Operation
- States: IDLE (buffer empty) and EMIT (buffer holds a word, nibble index idx = 0..3).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, latch in_word, set idx=0 and go to EMIT.
- EMIT:
  - out_valid=1.
  - out_sample = level(code at idx).
  - On out_ready with idx<3: idx increments.
  - On out_ready with idx=3: if in_valid, latch the new word, set idx=0 and stay in EMIT; otherwise go to IDLE.
- in_ready = (state==IDLE) || (idx==3 && out_ready). This gives back-to-back words with no bubble.
- Nibble order is LSB first: code 0 is emitted first.
- Inverse quantization (mid-rise, 16 levels): level(c) = ((c − 8) << 12) + 2048, signed 16-bit.
  - Examples: c=0 → −30720 (16'h8800), c=8 → 2048, c=15 → 30720.
  - Never saturates.
- out_sample = 16'h0000 whenever out_valid=0.
- Frame counter fcnt (16-bit):
  - Increments on each output handshake (out_valid && out_ready).
  - out_last = out_valid && (fcnt == FRAME_LEN−1).
  - Wraps to 0 on the handshake where out_last=1.
  - With FRAME_LEN=1, out_last is high on every sample.
- Backpressure: while out_ready=0, out_sample, out_last, idx and the buffer hold stable, and in_ready=0.
- Input that arrives while in_ready=0 is not consumed; the source must hold it.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, idx=0, buffer=0, fcnt=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_sample=0, out_last=0.
- Reset mid-word discards the remaining codes and the frame position.
- Latency: a word accepted at edge n gives its code 0 on out_sample from after edge n until the handshake.
  - With out_ready held high, codes 1, 2, 3 follow at n+1, n+2, n+3.
- Throughput: 1 sample/cycle, 1 word per 4 cycles; in_ready pulses one cycle in four during sustained streaming.
- Output signals are derived only from registers. out_ready → in_ready is the only combinational path.

## Structure
- Shared package quan_pkg contains:
  - CODE_W=4, SAMPLE_W=16, CODES_PER_WORD=4.
  - The state enum {IDLE, EMIT}.
  - The level function (constants 8, 12, 2048).
  - The encoder-side packer uses the same package.
- Sub-module iquan_level: a combinational 4-bit code → 16-bit level mapper, instantiated once on the selected nibble.
- Top-level contents: FSM, buffer, idx and frame counter.

## Test plan
- Reset, then in_word=16'h0F80 with out_ready=1 → out_sample sequence 16'h8800, 16'h0800, 16'h7800, 16'h8800 on consecutive cycles; then out_valid=0 and in_ready=1.
- Streaming, with in_valid held high and words 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC → 16 samples for codes 0..15 with no gap. Values run from −30720 to 30720 in steps of 4096. in_ready pulses exactly on idx=3 beats.
- Backpressure: drop out_ready for 5 cycles mid-word (at idx=1) → out_sample stable, in_ready=0 throughout. No code is lost or duplicated after out_ready returns.
- Frame marker, FRAME_LEN=6, 3 words streamed → out_last high on samples 5 and 11 only. fcnt wraps; stalls on out_ready do not shift the marker position.
- Reset mid-stream: assert reset at idx=2 → out_valid and out_last drop to 0 at once and in_ready=1. The next word starts at code 0 and fcnt=0.
- Idle input: in_valid=0 for 10 cycles after the last word → out_valid=0 and out_sample=0; state stays IDLE.

Source files
------------

// File: rtl/quan_pkg.sv
// Shared definitions for the quantized audio stream: code/sample geometry,
// the unpacker state set and the mid-rise inverse quantizer.
package quan_pkg;

    localparam int CODE_W         = 4;
    localparam int SAMPLE_W       = 16;
    localparam int CODES_PER_WORD = 4;

    localparam int LVL_OFFSET = 8;
    localparam int LVL_SHIFT  = 12;
    localparam int LVL_BIAS   = 2048;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Mid-rise level: ((c - 8) << 12) + 2048, evaluated modulo 2^16 so the
    // bit pattern is the signed result; the range fits, nothing saturates.
    function automatic logic [SAMPLE_W-1:0] level_of(input logic [CODE_W-1:0] code);
        logic [SAMPLE_W-1:0] centred;
        centred = SAMPLE_W'(code) - SAMPLE_W'(LVL_OFFSET);
        return (centred << LVL_SHIFT) + SAMPLE_W'(LVL_BIAS);
    endfunction

endpackage

// File: rtl/iquan_unpack_if.sv
// Packed-word input and sample output handshakes of the unpacker.
interface iquan_unpack_if;
    import quan_pkg::*;

    logic [CODES_PER_WORD*CODE_W-1:0] in_word;
    logic                             in_valid;
    logic                             in_ready;
    logic [SAMPLE_W-1:0]              out_sample;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_sample, out_valid, out_last
    );

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_sample, out_valid, out_last
    );

endinterface

// File: rtl/iquan_level.sv
// Combinational code to reconstruction-level mapper.
module iquan_level
    import quan_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [SAMPLE_W-1:0] level
);

    // Single mapper shared by every nibble position.
    assign level = level_of(code);

endmodule

// File: rtl/iquan_unpack.sv
// Unpacks four 4-bit codes per input word (LSB nibble first) and emits one
// reconstructed sample per output handshake, marking frame ends.
//
// state | meaning
// IDLE  | buffer empty, waiting for a packed word
// EMIT  | buffer holds a word, presenting the code at idx
module iquan_unpack
    import quan_pkg::*;
#(
    parameter int FRAME_LEN = 256
) (
    input  logic           clk,
    input  logic           reset,
    iquan_unpack_if.slave  bus
);

    localparam logic [1:0]  LAST_IDX = 2'(CODES_PER_WORD - 1);
    localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

    state_t                           state;
    logic [1:0]                       idx;
    logic [CODES_PER_WORD*CODE_W-1:0] word_buf;
    logic [15:0]                      fcnt;

    logic [CODE_W-1:0]   code_sel;
    logic [SAMPLE_W-1:0] level;
    logic                emitting;
    logic                out_hs;
    logic                last_beat;

    assign code_sel  = word_buf[{idx, 2'b00} +: CODE_W];
    assign emitting  = (state == EMIT);
    assign out_hs    = emitting && bus.out_ready;
    assign last_beat = emitting && (fcnt == LAST_CNT);

    iquan_level u_level (
        .code  (code_sel),
        .level (level)
    );

    // Outputs come from registers; out_ready reaches in_ready so a new word
    // can be taken on the last nibble's handshake without a bubble.
    assign bus.out_valid  = emitting;
    assign bus.out_sample = emitting ? level : '0;
    assign bus.out_last   = last_beat;
    assign bus.in_ready   = (state == IDLE) || (emitting && (idx == LAST_IDX) && bus.out_ready);

    // Word buffer, nibble index and state sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            word_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word_buf <= bus.in_word;
                        idx      <= '0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx + 2'd1;
                        end else if (bus.in_valid) begin
                            word_buf <= bus.in_word;
                            idx      <= '0;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Frame position counts delivered samples only, so stalls never move it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt <= '0;
        end else if (out_hs) begin
            fcnt <= last_beat ? 16'd0 : fcnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_iquan_unpack.sv
// Bench for iquan_unpack: queue-based reference model of the sample stream
// plus directed checks of literal sequences and frame markers.
module tb_iquan_unpack;

    localparam int FL = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    iquan_unpack_if bus();

    always #5 clk = ~clk;

    iquan_unpack #(.FRAME_LEN(FL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int          mq[$];      // expected samples still to be delivered
    int          mcount = 0; // samples delivered since reset
    int          log_s[$];   // observed delivered samples (current phase)
    bit          log_l[$];   // observed out_last on delivered samples
    logic [15:0] wq[$];      // words to send in current phase
    int          last_cyc;

    function automatic int ref_level(input int c);
        return (c - 8) * 4096 + 2048;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at negedge against the model, advance model.
    task automatic step(input logic iv, input logic [15:0] w, input logic ordy, output logic accepted);
        logic exp_v, exp_l, exp_r;
        int   exp_s;
        bus.in_valid  = iv;
        bus.in_word   = w;
        bus.out_ready = ordy;
        @(negedge clk);
        exp_v = (mq.size() > 0);
        exp_s = exp_v ? mq[0] : 0;
        exp_l = exp_v && ((mcount % FL) == FL - 1);
        exp_r = (mq.size() == 0) || (mq.size() == 1 && ordy);
        chk("out_valid",  32'(bus.out_valid), 32'(exp_v));
        chk("out_sample", 32'($signed(bus.out_sample)), exp_s);
        chk("out_last",   32'(bus.out_last), 32'(exp_l));
        chk("in_ready",   32'(bus.in_ready), 32'(exp_r));
        if (exp_v && ordy) begin
            log_s.push_back(int'($signed(bus.out_sample)));
            log_l.push_back(bus.out_last);
            void'(mq.pop_front());
            mcount++;
        end
        accepted = iv && exp_r;
        if (accepted)
            for (int k = 0; k < 4; k++) mq.push_back(ref_level(int'((w >> (4 * k)) & 16'hF)));
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready high; 1: random out_ready; 2: random out_ready and in_valid gaps.
    task automatic run_words(input int mode, input int stall_at, input int stall_len);
        int   ptr  = 0;
        int   left = stall_len;
        int   cyc  = 0;
        logic acc, ordy, iv;
        log_s.delete();
        log_l.delete();
        while ((ptr < wq.size() || mq.size() > 0) && cyc < 400) begin
            ordy = 1'b1;
            iv   = (ptr < wq.size());
            if (mode >= 1) ordy = 1'($urandom_range(0, 1));
            if (mode == 2 && $urandom_range(0, 3) == 0) iv = 1'b0;
            if (log_s.size() == stall_at && left > 0) begin
                ordy = 1'b0;
                left--;
            end
            step(iv, (ptr < wq.size()) ? wq[ptr] : 16'h0, ordy, acc);
            if (acc) ptr++;
            cyc++;
        end
        chk("drain_in_budget", 32'(cyc < 400), 32'd1);
        last_cyc = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_out_last",   32'(bus.out_last), 32'd0);
        chk("rst_in_ready",   32'(bus.in_ready), 32'd1);
        chk("rst_out_sample", 32'(bus.out_sample), 32'd0);
        mq.delete();
        mcount = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        int   exp1[4];
        logic [15:0] w0;

        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        #1;
        do_reset();

        // Single word, then back to idle.
        wq.delete();
        wq.push_back(16'h0F80);
        run_words(0, -1, 0);
        step(1'b0, 16'h0, 1'b1, acc);
        exp1 = '{-30720, 2048, 30720, -30720};
        chk("single_count", log_s.size(), 4);
        for (int i = 0; i < log_s.size() && i < 4; i++) chk("single_seq", log_s[i], exp1[i]);

        // Back-to-back streaming of all 16 codes.
        wq.delete();
        wq.push_back(16'h3210); wq.push_back(16'h7654);
        wq.push_back(16'hBA98); wq.push_back(16'hFEDC);
        run_words(0, -1, 0);
        chk("stream_count", log_s.size(), 16);
        chk("stream_nogap", last_cyc, 17);
        for (int i = 0; i < log_s.size(); i++) chk("stream_seq", log_s[i], -30720 + 4096 * i);

        // Five-cycle stall at idx=1.
        wq.delete();
        w0 = 16'($urandom);
        wq.push_back(w0); wq.push_back(16'($urandom));
        run_words(0, 1, 5);
        chk("stall_count", log_s.size(), 8);
        chk("stall_cycles", last_cyc, 14);
        for (int i = 0; i < 4 && i < log_s.size(); i++)
            chk("stall_seq", log_s[i], ref_level(int'((w0 >> (4 * i)) & 16'hF)));

        // Frame marker with random stalls from a fresh frame position.
        do_reset();
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(16'($urandom));
        run_words(1, -1, 0);
        chk("frame_count", log_s.size(), 12);
        for (int i = 0; i < log_l.size(); i++) chk("frame_last", 32'(log_l[i]), 32'(i == 5 || i == 11));

        // Reset at idx=2 mid-word.
        w0 = 16'($urandom);
        step(1'b1, w0, 1'b1, acc);
        step(1'b0, 16'h0, 1'b1, acc);
        step(1'b0, 16'h0, 1'b1, acc);
        do_reset();
        wq.delete();
        w0 = 16'($urandom);
        wq.push_back(w0); wq.push_back(16'($urandom));
        run_words(0, -1, 0);
        chk("after_rst_count", log_s.size(), 8);
        if (log_s.size() == 8) begin
            chk("after_rst_code0", log_s[0], ref_level(int'(w0 & 16'hF)));
            chk("after_rst_last4", 32'(log_l[4]), 32'd0);
            chk("after_rst_last5", 32'(log_l[5]), 32'd1);
        end

        // Random soak with source gaps and sink stalls.
        for (int r = 0; r < 5; r++) begin
            wq.delete();
            for (int i = 0; i < 8; i++) wq.push_back(16'($urandom));
            run_words(2, -1, 0);
            chk("soak_count", log_s.size(), 32);
        end

        // Idle input.
        for (int i = 0; i < 10; i++) step(1'b0, 16'($urandom), 1'($urandom_range(0, 1)), acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
